benes_egress_buffer: RTL and testbench

Egress stage placed directly after the 8x8 Benes interconnect in the ANN co-processor. It takes the registered 160-bit network output (8 lanes, each a 16-bit datum plus a 4-bit source tag) and checks every lane's tag against the expected route. It strips the tags, queues the 128-bit payload with a per-lane enable mask in a small FIFO, and hands words to the downstream neuron array over a valid/ready handshake. Route mismatches are recorded in sticky error status and a saturating error counter.

---
 rtl/benes_egress_buffer.sv | 113 +++++++++++
 tb/tb_benes_egress_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/benes_egress_buffer.sv
// Egress buffer behind the 8x8 Benes network. It checks lane tags against the expected route,
// strips the tags and queues the payloads for the neuron array. Optional macro: BENES_EGRESS_DROP_ON_ERR_EN.
module benes_egress_buffer #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [159:0]   in_output,
   input  logic [31:0]    in_expect,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   out_data,
   output logic [7:0]     out_lane_en,
   output logic [LW-1:0]  level,
   output logic           err_flag,
   output logic [7:0]     err_lane,
   output logic [7:0]     err_count,
   input  logic           clr_err
);

   localparam int PW = $clog2(DEPTH);

   logic [127:0]  r_mem_data [DEPTH];
   logic [7:0]    r_mem_en   [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_err_flag;
   logic [7:0]    r_err_lane;
   logic [7:0]    r_err_count;

   logic [127:0]  w_data;
   logic [7:0]    w_en;
   logic [7:0]    w_mismatch;
   logic          w_accept;
   logic          w_err_word;
   logic          w_push;
   logic          w_pop;

   // Idle lanes (tag F) are zeroed; every lane is checked against its expected tag.
   always_comb begin
      w_data     = '0;
      w_en       = '0;
      w_mismatch = '0;
      for (int i = 0; i < 8; i++) begin
         if (in_output[143-20*i -: 4] != 4'hF) begin
            w_data[127-16*i -: 16] = in_output[159-20*i -: 16];
            w_en[i]                = 1'b1;
         end
         w_mismatch[i] = (in_output[143-20*i -: 4] != in_expect[31-4*i -: 4]);
      end
   end

   assign in_ready   = (r_level != LW'(DEPTH));
   assign out_valid  = (r_level != '0);
   assign w_accept   = in_valid & in_ready;
   assign w_err_word = w_accept & (|w_mismatch);
   assign w_pop      = out_valid & out_ready;
`ifdef BENES_EGRESS_DROP_ON_ERR_EN
   assign w_push     = w_accept & ~w_err_word;
`else
   assign w_push     = w_accept;
`endif

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= w_data;
         r_mem_en[r_wr_ptr]   <= w_en;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push && !w_pop)      r_level <= r_level + LW'(1);
         else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      end
   end

   // A clear in the same cycle as an error word leaves only that word's contribution.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_flag  <= 1'b0;
         r_err_lane  <= '0;
         r_err_count <= '0;
      end else if (clr_err) begin
         r_err_flag  <= w_err_word;
         r_err_lane  <= w_err_word ? w_mismatch : 8'h00;
         r_err_count <= w_err_word ? 8'h01 : 8'h00;
      end else if (w_err_word) begin
         r_err_flag  <= 1'b1;
         r_err_lane  <= r_err_lane | w_mismatch;
         if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'h01;
      end
   end

   assign out_data    = out_valid ? r_mem_data[r_rd_ptr] : '0;
   assign out_lane_en = out_valid ? r_mem_en[r_rd_ptr]   : '0;
   assign level       = r_level;
   assign err_flag    = r_err_flag;
   assign err_lane    = r_err_lane;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_benes_egress_buffer.sv
// Directed bench for benes_egress_buffer: decode, error status, FIFO backpressure, saturation, async reset.
// Honours BENES_EGRESS_DROP_ON_ERR_EN when defined.
module tb_benes_egress_buffer;

   localparam int DEPTH = 4;
   localparam int LW    = 3;
   localparam logic [31:0] T_SEQ  = 32'h01234567;
   localparam logic [31:0] T_IDLE = 32'h01F34F67;
   localparam logic [31:0] T_BAD  = 32'h01264567;

`ifdef BENES_EGRESS_DROP_ON_ERR_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [159:0]   in_output;
   logic [31:0]    in_expect;
   logic           out_valid;
   logic           out_ready;
   logic [127:0]   out_data;
   logic [7:0]     out_lane_en;
   logic [LW-1:0]  level;
   logic           err_flag;
   logic [7:0]     err_lane;
   logic [7:0]     err_count;
   logic           clr_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] exp_q[$];

   benes_egress_buffer #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_output(in_output), .in_expect(in_expect),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane_en(out_lane_en),
      .level(level), .err_flag(err_flag), .err_lane(err_lane), .err_count(err_count),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [159:0] mk_word(input logic [15:0] base, input logic [31:0] tags);
      logic [159:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w[159-20*i -: 16] = base + 16'(i);
         w[143-20*i -: 4]  = tags[31-4*i -: 4];
      end
      return w;
   endfunction

   function automatic logic [127:0] mk_data(input logic [15:0] base, input logic [31:0] tags);
      logic [127:0] d;
      d = '0;
      for (int i = 0; i < 8; i++)
         if (tags[31-4*i -: 4] != 4'hF) d[127-16*i -: 16] = base + 16'(i);
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_output = '0; in_expect = '0; out_ready = 1'b0; clr_err = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      n_checks++; if ({err_flag, err_lane, err_count} !== 17'h0) begin n_fail++; $display("FAIL reset_err: got %b %h %h want 0", err_flag, err_lane, err_count); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      in_valid = 1'b1; in_output = mk_word(16'h1000, T_SEQ); in_expect = T_SEQ;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      n_checks++; if (out_data !== 128'h1000_1001_1002_1003_1004_1005_1006_1007) begin n_fail++; $display("FAIL basic_data: got %h", out_data); end
      n_checks++; if (out_lane_en !== 8'hFF) begin n_fail++; $display("FAIL basic_en: got %h want ff", out_lane_en); end
      n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err_flag); end
      n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL basic_level: got %0d want 1", level); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got level %0d valid %b want 0 0", level, out_valid); end
   endtask

   task automatic test_idle_lanes();
      in_valid = 1'b1; in_output = mk_word(16'h1000, T_IDLE); in_expect = T_IDLE;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_lane_en !== 8'hDB) begin n_fail++; $display("FAIL idle_en: got %h want db", out_lane_en); end
      n_checks++; if (out_data !== 128'h1000_1001_0000_1003_1004_0000_1006_1007) begin n_fail++; $display("FAIL idle_data: got %h", out_data); end
      n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b want 0", err_flag); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_mismatch();
      int budget;
      in_valid = 1'b1; in_output = mk_word(16'h2000, T_BAD); in_expect = T_SEQ;
      step();
      step();
      in_valid = 1'b0;
      n_checks++; if (err_lane !== 8'h08) begin n_fail++; $display("FAIL mm_lane: got %h want 08", err_lane); end
      n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL mm_count: got %0d want 2", err_count); end
      n_checks++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL mm_flag: got %b want 1", err_flag); end
      n_checks++; if (level !== (DROP ? 3'd0 : 3'd2)) begin n_fail++; $display("FAIL mm_level: got %0d want %0d", level, DROP ? 0 : 2); end
      if (!DROP) begin
         n_checks++; if (out_data !== mk_data(16'h2000, T_BAD) || out_lane_en !== 8'hFF) begin n_fail++; $display("FAIL mm_head: got %h en %h", out_data, out_lane_en); end
      end
      in_valid = 1'b1; clr_err = 1'b1;
      step();
      in_valid = 1'b0; clr_err = 1'b0;
      n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL mm_clr_count: got %0d want 1", err_count); end
      n_checks++; if (err_lane !== 8'h08 || err_flag !== 1'b1) begin n_fail++; $display("FAIL mm_clr_lane: got %h %b want 08 1", err_lane, err_flag); end
      n_checks++; if (level !== (DROP ? 3'd0 : 3'd3)) begin n_fail++; $display("FAIL mm_clr_level: got %0d want %0d", level, DROP ? 0 : 3); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_checks++; if ({err_flag, err_lane, err_count} !== 17'h0) begin n_fail++; $display("FAIL mm_clear: got %b %h %h want 0", err_flag, err_lane, err_count); end
      out_ready = 1'b1;
      budget = 0;
      while (level != 0 && budget < 10) begin step(); budget++; end
      out_ready = 1'b0;
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL mm_drain: got level %0d want 0 within budget", level); end
   endtask

   task automatic test_backpressure();
      logic [127:0] exp;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_output = mk_word(16'h3000 + 16'(k*16), T_SEQ); in_expect = T_SEQ;
         if (k < DEPTH) exp_q.push_back(mk_data(16'h3000 + 16'(k*16), T_SEQ));
         step();
      end
      in_valid = 1'b0;
      n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", level); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", in_ready); end
      out_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         exp = exp_q.pop_front();
         n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", k, out_data, exp); end
         step();
      end
      out_ready = 1'b0;
      n_checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got level %0d valid %b", level, out_valid); end
   endtask

   task automatic test_full_push_pop();
      logic [127:0] exp;
      out_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = 1'b1; in_output = mk_word(16'h4000 + 16'(k*16), T_SEQ); in_expect = T_SEQ;
         if (k > 0) exp_q.push_back(mk_data(16'h4000 + 16'(k*16), T_SEQ));
         step();
      end
      in_output = mk_word(16'h4800, T_SEQ); out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL full_level: got %0d want 3", level); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready: got %b want 1", in_ready); end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp = exp_q.pop_front();
         n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL full_order%0d: got %h want %h", k, out_data, exp); end
         step();
      end
      out_ready = 1'b0;
      n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL full_empty: got level %0d want 0", level); end
   endtask

   task automatic test_saturation();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_output = mk_word(16'h5000, T_BAD); in_expect = T_SEQ;
      repeat (300) step();
      in_valid = 1'b0;
      n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_count: got %h want ff", err_count); end
      n_checks++; if (err_flag !== 1'b1 || err_lane !== 8'h08) begin n_fail++; $display("FAIL sat_status: got %b %h want 1 08", err_flag, err_lane); end
      n_checks++; if (level !== (DROP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL sat_stream_level: got %0d want %0d", level, DROP ? 0 : 1); end
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_output = mk_word(16'h6000, T_SEQ); in_expect = T_SEQ;
      step();
      step();
      in_valid = 1'b0;
      n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL ar_pre_level: got %0d want 2", level); end
      #1 rst = 1'b0;
      #1;
      n_checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_fifo: got level %0d valid %b", level, out_valid); end
      n_checks++; if ({err_flag, err_lane, err_count} !== 17'h0) begin n_fail++; $display("FAIL ar_err: got %b %h %h want 0", err_flag, err_lane, err_count); end
      n_checks++; if (out_data !== 128'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_outs: got %h ready %b", out_data, in_ready); end
      @(negedge clk);
      rst = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_replay: got valid %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_idle_lanes();
      test_mismatch();
      test_backpressure();
      test_full_push_pop();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
